imuldiv_div_client: RTL and testbench

Requester side of the divider val/rdy protocol. It accepts one divide/remainder operation from the pipeline and drives a divreq transaction to the iterative divider. It then collects the 64-bit divresp, selects the quotient or remainder, and returns a tagged 32-bit writeback. One operation is in flight at a time, and the block records the divider round-trip latency for perf counters.

---
 rtl/imuldiv_div_client.sv | 212 +++++++++++++++++++++
 tb/tb_imuldiv_div_client.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imuldiv_div_client.sv
// imuldiv_div_client
// Requester side of the iterative divider val/rdy protocol. One divide or
// remainder op is held at a time: it is latched from the pipeline, issued as
// a divreq, the 64-bit divresp is narrowed to quotient or remainder, and the
// result goes out as a tagged writeback. The round-trip latency of the most
// recent divider transaction is kept for perf counters.
//
// Every val/rdy output comes straight from a flop, decoded from the next
// state. No val output therefore depends combinationally on its rdy input.

module imuldiv_div_client #(
    parameter int TAG_W = 5,
    parameter int LAT_W = 8
) (
    input  logic             clk,
    input  logic             reset,

    // Upstream op interface
    input  logic             op_val,
    output logic             op_rdy,
    input  logic             op_fn,
    input  logic             op_rem,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic [TAG_W-1:0] op_tag,

    // Divider request
    output logic             divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    output logic             divreq_val,
    input  logic             divreq_rdy,

    // Divider response: {remainder, quotient}
    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,

    // Writeback
    output logic             wb_val,
    input  logic             wb_rdy,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,

    // Status
    output logic [LAT_W-1:0] lat_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    localparam logic [LAT_W-1:0] LAT_MAX = '1;
    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

    // Control state
    state_t           state_q, state_d;

    // Latched operation
    logic             fn_q,  fn_d;
    logic             rem_q, rem_d;
    logic [31:0]      a_q,   a_d;
    logic [31:0]      b_q,   b_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // Latency tracking
    logic [LAT_W-1:0] lat_cnt_q,  lat_cnt_d;
    logic [LAT_W-1:0] lat_last_q, lat_last_d;
    logic [LAT_W-1:0] lat_inc;

    // Writeback payload
    logic [31:0]      wb_data_q, wb_data_d;
    logic [TAG_W-1:0] wb_tag_q,  wb_tag_d;

    // Registered handshake outputs
    logic             op_rdy_q,      op_rdy_d;
    logic             divreq_val_q,  divreq_val_d;
    logic             divresp_rdy_q, divresp_rdy_d;
    logic             wb_val_q,      wb_val_d;
    logic             busy_q,        busy_d;

    // Transfer strobes, qualified by our own registered val/rdy
    logic             op_fire;
    logic             req_fire;
    logic             resp_fire;
    logic             wb_fire;
    logic [31:0]      result_sel;

    assign op_fire   = op_rdy_q      & op_val;
    assign req_fire  = divreq_val_q  & divreq_rdy;
    assign resp_fire = divresp_rdy_q & divresp_val;
    assign wb_fire   = wb_val_q      & wb_rdy;

    // Saturating increment: the counter parks at all-ones instead of wrapping
    assign lat_inc = (lat_cnt_q == LAT_MAX) ? LAT_MAX : (lat_cnt_q + LAT_ONE);

    // Pick the half of the divider response the op asked for; no arithmetic
    assign result_sel = rem_q ? divresp_msg_result[63:32] : divresp_msg_result[31:0];

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        fn_d       = fn_q;
        rem_d      = rem_q;
        a_d        = a_q;
        b_d        = b_q;
        tag_d      = tag_q;
        lat_cnt_d  = lat_cnt_q;
        lat_last_d = lat_last_q;
        wb_data_d  = wb_data_q;
        wb_tag_d   = wb_tag_q;

        case (state_q)
            IDLE: begin
                if (op_fire) begin
                    fn_d      = op_fn;
                    rem_d     = op_rem;
                    a_d       = op_a;
                    b_d       = op_b;
                    tag_d     = op_tag;
                    lat_cnt_d = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = lat_inc;
                if (req_fire) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_cnt_d = lat_inc;
                if (resp_fire) begin
                    wb_data_d  = result_sel;
                    wb_tag_d   = tag_q;
                    // lat_inc already includes this response cycle
                    lat_last_d = lat_inc;
                    state_d    = WB;
                end
            end
            WB: begin
                if (wb_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs follow the state we are about to enter
        op_rdy_d      = (state_d == IDLE);
        divreq_val_d  = (state_d == ISSUE);
        divresp_rdy_d = (state_d == WAIT);
        wb_val_d      = (state_d == WB);
        busy_d        = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            fn_q          <= 1'b0;
            rem_q         <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            tag_q         <= '0;
            lat_cnt_q     <= '0;
            lat_last_q    <= '0;
            wb_data_q     <= '0;
            wb_tag_q      <= '0;
            op_rdy_q      <= 1'b1;
            divreq_val_q  <= 1'b0;
            divresp_rdy_q <= 1'b0;
            wb_val_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fn_q          <= fn_d;
            rem_q         <= rem_d;
            a_q           <= a_d;
            b_q           <= b_d;
            tag_q         <= tag_d;
            lat_cnt_q     <= lat_cnt_d;
            lat_last_q    <= lat_last_d;
            wb_data_q     <= wb_data_d;
            wb_tag_q      <= wb_tag_d;
            op_rdy_q      <= op_rdy_d;
            divreq_val_q  <= divreq_val_d;
            divresp_rdy_q <= divresp_rdy_d;
            wb_val_q      <= wb_val_d;
            busy_q        <= busy_d;
        end
    end

    assign op_rdy        = op_rdy_q;
    assign divreq_val    = divreq_val_q;
    assign divreq_msg_fn = fn_q;
    assign divreq_msg_a  = a_q;
    assign divreq_msg_b  = b_q;
    assign divresp_rdy   = divresp_rdy_q;
    assign wb_val        = wb_val_q;
    assign wb_data       = wb_data_q;
    assign wb_tag        = wb_tag_q;
    assign lat_last      = lat_last_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_imuldiv_div_client.sv
// Directed testbench for imuldiv_div_client. The bench plays the divider and
// the writeback consumer itself, drives on the falling edge and samples on
// the falling edge, and checks against hand-computed values.

module tb_imuldiv_div_client;

    localparam int TAG_W = 5;
    localparam int LAT_W = 8;

    logic             clk;
    logic             reset;
    logic             op_val;
    logic             op_rdy;
    logic             op_fn;
    logic             op_rem;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [TAG_W-1:0] op_tag;
    logic             divreq_msg_fn;
    logic [31:0]      divreq_msg_a;
    logic [31:0]      divreq_msg_b;
    logic             divreq_val;
    logic             divreq_rdy;
    logic [63:0]      divresp_msg_result;
    logic             divresp_val;
    logic             divresp_rdy;
    logic             wb_val;
    logic             wb_rdy;
    logic [31:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic [LAT_W-1:0] lat_last;
    logic             busy;

    int errors = 0;
    int checks = 0;

    // Observations recorded by the op driver, compared by the test tasks
    logic [31:0]      obs_data;
    logic [TAG_W-1:0] obs_tag;
    int               obs_wb_n;
    bit               obs_timeout;
    bit               obs_req_bad;
    bit               obs_wb_bad;

    imuldiv_div_client #(.TAG_W(TAG_W), .LAT_W(LAT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .op_val             (op_val),
        .op_rdy             (op_rdy),
        .op_fn              (op_fn),
        .op_rem             (op_rem),
        .op_a               (op_a),
        .op_b               (op_b),
        .op_tag             (op_tag),
        .divreq_msg_fn      (divreq_msg_fn),
        .divreq_msg_a       (divreq_msg_a),
        .divreq_msg_b       (divreq_msg_b),
        .divreq_val         (divreq_val),
        .divreq_rdy         (divreq_rdy),
        .divresp_msg_result (divresp_msg_result),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy),
        .wb_val             (wb_val),
        .wb_rdy             (wb_rdy),
        .wb_data            (wb_data),
        .wb_tag             (wb_tag),
        .lat_last           (lat_last),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one op through the block, acting as divider and consumer.
    // Edge count n: the accept edge is 1, so wb_val seen after edge n means
    // wb_val arrived in cycle n counting the accept cycle as 1.
    task automatic run_op(input logic fn, input logic rem,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag,
                          input int req_stall, input int resp_delay,
                          input int wb_stall, input logic [63:0] result);
        int n;
        int guard;
        obs_timeout = 0;
        obs_req_bad = 0;
        obs_wb_bad  = 0;
        obs_wb_n    = -1;
        guard       = 0;
        @(negedge clk);
        while (op_rdy !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            obs_timeout = 1;
            return;
        end
        op_val = 1'b1; op_fn = fn; op_rem = rem; op_a = a; op_b = b; op_tag = tag;
        @(posedge clk); n = 1;
        @(negedge clk);
        op_val = 1'b0; op_a = 32'h0; op_b = 32'h0; op_tag = '0;
        // Request phase, optionally stalled
        for (int i = 0; i < req_stall; i++) begin
            if (divreq_val !== 1'b1 || divreq_msg_a !== a || divreq_msg_b !== b ||
                divreq_msg_fn !== fn || op_rdy !== 1'b0)
                obs_req_bad = 1;
            divreq_rdy = 1'b0;
            @(posedge clk); n++;
            @(negedge clk);
        end
        if (divreq_val !== 1'b1 || divreq_msg_a !== a || divreq_msg_b !== b ||
            divreq_msg_fn !== fn)
            obs_req_bad = 1;
        divreq_rdy = 1'b1;
        @(posedge clk); n++;
        @(negedge clk);
        divreq_rdy = 1'b0;
        // Response phase: response sampled resp_delay edges after the request
        for (int i = 1; i < resp_delay; i++) begin
            if (divresp_rdy !== 1'b1 || divreq_val !== 1'b0) obs_req_bad = 1;
            if (wb_val !== 1'b0) obs_wb_bad = 1;
            @(posedge clk); n++;
            @(negedge clk);
        end
        if (divresp_rdy !== 1'b1 || wb_val !== 1'b0) obs_req_bad = 1;
        divresp_val = 1'b1;
        divresp_msg_result = result;
        @(posedge clk); n++;
        @(negedge clk);
        divresp_val = 1'b0;
        divresp_msg_result = 64'h0;
        guard = 0;
        while (wb_val !== 1'b1 && guard < 10) begin
            @(posedge clk); n++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) begin
            obs_timeout = 1;
            return;
        end
        obs_wb_n = n;
        obs_data = wb_data;
        obs_tag  = wb_tag;
        // Writeback phase, optionally backpressured
        for (int i = 0; i < wb_stall; i++) begin
            wb_rdy = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (wb_val !== 1'b1 || wb_data !== obs_data || wb_tag !== obs_tag)
                obs_wb_bad = 1;
        end
        wb_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wb_rdy = 1'b0;
        if (wb_val !== 1'b0 || op_rdy !== 1'b1 || busy !== 1'b0) obs_wb_bad = 1;
        $display("op tag=%0d data=%h wb_cycle=%0d lat_last=%0d", obs_tag, obs_data, obs_wb_n, lat_last);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op_val = 1'b0; op_fn = 1'b0; op_rem = 1'b0; op_a = 32'h0; op_b = 32'h0; op_tag = '0;
        divreq_rdy = 1'b0; divresp_val = 1'b0; divresp_msg_result = 64'h0; wb_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (op_rdy !== 1'b1 || divreq_val !== 1'b0 || divresp_rdy !== 1'b0 || wb_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: got op_rdy=%b divreq_val=%b divresp_rdy=%b wb_val=%b expected 1 0 0 0",
                     op_rdy, divreq_val, divresp_rdy, wb_val);
        end
        checks++;
        if (wb_data !== 32'h0 || wb_tag !== '0 || lat_last !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got wb_data=%h wb_tag=%0d lat_last=%0d busy=%b expected 0 0 0 0",
                     wb_data, wb_tag, lat_last, busy);
        end
        checks++;
        if (divreq_msg_a !== 32'h0 || divreq_msg_b !== 32'h0 || divreq_msg_fn !== 1'b0) begin
            errors++;
            $display("FAIL reset_opregs: got a=%h b=%h fn=%b expected 0", divreq_msg_a, divreq_msg_b, divreq_msg_fn);
        end
        $display("reset done");
    endtask

    task automatic test_unsigned_quotient();
        run_op(1'b0, 1'b0, 32'd100, 32'd7, 5'd3, 0, 1, 0, {32'd2, 32'd14});
        checks++;
        if (obs_timeout || obs_req_bad || obs_wb_bad) begin
            errors++;
            $display("FAIL uquot_protocol: got timeout=%b req_bad=%b wb_bad=%b expected 0 0 0",
                     obs_timeout, obs_req_bad, obs_wb_bad);
        end
        checks++;
        if (obs_data !== 32'd14 || obs_tag !== 5'd3) begin
            errors++;
            $display("FAIL uquot_data: got data=%0d tag=%0d expected 14 3", obs_data, obs_tag);
        end
        checks++;
        if (obs_wb_n !== 3) begin
            errors++;
            $display("FAIL uquot_wb_latency: got cycle %0d expected 3", obs_wb_n);
        end
        checks++;
        if (lat_last !== 8'd2) begin
            errors++;
            $display("FAIL uquot_lat_last: got %0d expected 2", lat_last);
        end
    endtask

    task automatic test_signed();
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd9, 0, 1, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        checks++;
        if (obs_timeout || obs_req_bad || obs_wb_bad || obs_data !== 32'hFFFF_FFFF || obs_tag !== 5'd9) begin
            errors++;
            $display("FAIL signed_rem: got data=%h tag=%0d flags=%b%b%b expected ffffffff 9 000",
                     obs_data, obs_tag, obs_timeout, obs_req_bad, obs_wb_bad);
        end
        run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd10, 0, 1, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        checks++;
        if (obs_timeout || obs_req_bad || obs_wb_bad || obs_data !== 32'hFFFF_FFFD || obs_tag !== 5'd10) begin
            errors++;
            $display("FAIL signed_quot: got data=%h tag=%0d flags=%b%b%b expected fffffffd 10 000",
                     obs_data, obs_tag, obs_timeout, obs_req_bad, obs_wb_bad);
        end
        checks++;
        if (lat_last !== 8'd2) begin
            errors++;
            $display("FAIL signed_lat_last: got %0d expected 2", lat_last);
        end
    endtask

    task automatic test_backpressure();
        run_op(1'b0, 1'b1, 32'd1000, 32'd0, 5'd17, 5, 33, 4, {32'h1234_5678, 32'hFFFF_FFFF});
        checks++;
        if (obs_timeout || obs_req_bad) begin
            errors++;
            $display("FAIL bp_request_stable: got timeout=%b req_bad=%b expected 0 0", obs_timeout, obs_req_bad);
        end
        checks++;
        if (obs_wb_bad || obs_data !== 32'h1234_5678 || obs_tag !== 5'd17) begin
            errors++;
            $display("FAIL bp_writeback_hold: got wb_bad=%b data=%h tag=%0d expected 0 12345678 17",
                     obs_wb_bad, obs_data, obs_tag);
        end
        checks++;
        if (lat_last !== 8'd39) begin
            errors++;
            $display("FAIL bp_lat_last: got %0d expected 39", lat_last);
        end
    endtask

    task automatic test_saturation_spurious();
        run_op(1'b0, 1'b0, 32'd50, 32'd5, 5'd21, 0, 300, 0, {32'd0, 32'd10});
        checks++;
        if (obs_timeout || obs_req_bad || obs_wb_bad || obs_data !== 32'd10) begin
            errors++;
            $display("FAIL sat_op: got data=%0d flags=%b%b%b expected 10 000",
                     obs_data, obs_timeout, obs_req_bad, obs_wb_bad);
        end
        checks++;
        if (lat_last !== 8'd255) begin
            errors++;
            $display("FAIL sat_lat_last: got %0d expected 255", lat_last);
        end
        // Spurious response while IDLE
        divresp_val = 1'b1;
        divresp_msg_result = 64'hAAAA_AAAA_5555_5555;
        @(posedge clk);
        @(negedge clk);
        divresp_val = 1'b0;
        divresp_msg_result = 64'h0;
        checks++;
        if (busy !== 1'b0 || wb_val !== 1'b0 || op_rdy !== 1'b1 || divresp_rdy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_state: got busy=%b wb_val=%b op_rdy=%b divresp_rdy=%b expected 0 0 1 0",
                     busy, wb_val, op_rdy, divresp_rdy);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (wb_val !== 1'b0 || wb_data !== 32'd10 || lat_last !== 8'd255) begin
            errors++;
            $display("FAIL spurious_regs: got wb_val=%b wb_data=%h lat_last=%0d expected 0 0000000a 255",
                     wb_val, wb_data, lat_last);
        end
        $display("spurious response pulse in IDLE");
    endtask

    task automatic test_back_to_back();
        logic [31:0]      exp_data;
        logic [TAG_W-1:0] exp_tag;
        int               wb_count;
        bit               bad_rdy;
        bit               bad_wbv;
        wb_count = 0;
        bad_rdy  = 0;
        bad_wbv  = 0;
        op_val = 1'b1; op_fn = 1'b0; op_rem = 1'b0; op_b = 32'd1;
        divreq_rdy = 1'b1;
        wb_rdy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (op_rdy !== (k % 4 == 0)) bad_rdy = 1;
            if (wb_val !== (k % 4 == 3)) bad_wbv = 1;
            if (wb_val === 1'b1) begin
                exp_tag  = TAG_W'(k / 4 + 1);
                exp_data = 32'((k / 4 + 1) * 100);
                wb_count++;
                checks++;
                if (wb_tag !== exp_tag || wb_data !== exp_data) begin
                    errors++;
                    $display("FAIL b2b_wb: got tag=%0d data=%0d expected tag=%0d data=%0d",
                             wb_tag, wb_data, exp_tag, exp_data);
                end
                $display("b2b writeback tag=%0d data=%0d", wb_tag, wb_data);
            end
            if (k % 4 == 0) begin
                op_tag = TAG_W'(k / 4 + 1);
                op_a   = 32'((k / 4 + 1) * 100);
            end
            divresp_val = (k % 4 == 2);
            divresp_msg_result = {32'h0, 32'((k / 4 + 1) * 100)};
            @(posedge clk);
            @(negedge clk);
        end
        op_val = 1'b0;
        divresp_val = 1'b0;
        divreq_rdy = 1'b0;
        wb_rdy = 1'b0;
        checks++;
        if (bad_rdy || bad_wbv || op_rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_timing: got op_rdy_bad=%b wb_val_bad=%b final op_rdy=%b expected 0 0 1",
                     bad_rdy, bad_wbv, op_rdy);
        end
        checks++;
        if (wb_count !== 3 || lat_last !== 8'd2) begin
            errors++;
            $display("FAIL b2b_count: got writebacks=%0d lat_last=%0d expected 3 2", wb_count, lat_last);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int saw_wb;
        saw_wb = 0;
        // Start an op and park it in WAIT
        op_val = 1'b1; op_fn = 1'b0; op_rem = 1'b0; op_a = 32'd77; op_b = 32'd7; op_tag = 5'd30;
        @(posedge clk);
        @(negedge clk);
        op_val = 1'b0;
        divreq_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        divreq_rdy = 1'b0;
        checks++;
        if (busy !== 1'b1 || divresp_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_wait: got busy=%b divresp_rdy=%b expected 1 1", busy, divresp_rdy);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (op_rdy !== 1'b1 || wb_val !== 1'b0 || lat_last !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got op_rdy=%b wb_val=%b lat_last=%0d busy=%b expected 1 0 0 0",
                     op_rdy, wb_val, lat_last, busy);
        end
        // A late response from the abandoned op must not produce a writeback
        divresp_val = 1'b1;
        divresp_msg_result = {32'd0, 32'd11};
        wb_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            divresp_val = 1'b0;
            if (wb_val === 1'b1) saw_wb++;
        end
        wb_rdy = 1'b0;
        checks++;
        if (saw_wb !== 0 || wb_data !== 32'h0 || wb_tag !== '0) begin
            errors++;
            $display("FAIL midreset_no_wb: got wb cycles=%0d wb_data=%h wb_tag=%0d expected 0 0 0",
                     saw_wb, wb_data, wb_tag);
        end
        $display("reset mid-op, abandoned tag 30");
    endtask

    initial begin
        test_reset();
        test_unsigned_quotient();
        test_signed();
        test_backpressure();
        test_saturation_spurious();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
